cpu_control: RTL and testbench

- Hardwired multi-cycle control unit that sequences fetch/decode/execute over the existing datapath: instruction ROM, 4x8 register file and 8-bit ALU.
- Drives the PC and ROM enable, register-file address/rd/wr/write-data, and ALU operands/opcode.
- Sits between inst_reg, registers and alu; the top-level wires the three around it.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_decode.sv | 32 +++
 rtl/cpu_control.sv | 176 +++++++++++++++++
 tb/tb_cpu_control.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op, instruction-field and FSM encodings for the multi-cycle
// control unit and its decoder.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_INV  = 4'h5;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_INV = 3'b101;

  localparam int OP_LO   = 12;
  localparam int DST_LO  = 8;
  localparam int SRCA_LO = 4;
  localparam int SRCB_LO = 0;
  localparam int IMM_LO  = 0;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_RD_A, ST_RD_B, ST_EXEC, ST_WB, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU2, CL_ALU1, CL_INCDEC, CL_LOAD, CL_JMP, CL_JNZ, CL_HLT, CL_NOP
  } class_e;

  // Where operand B comes from in EXEC
  typedef enum logic [1:0] {
    BS_REG, BS_ONE, BS_KEEP
  } bsrc_e;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: instruction class, ALU opcode and operand-B source.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [2:0] cls_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] bsrc_o
);

  always_comb begin
    cls_o    = CL_NOP;
    alu_op_o = ALU_ADD;
    bsrc_o   = BS_KEEP;
    case (op_i)
      OP_ADD:  begin cls_o = CL_ALU2;   alu_op_o = ALU_ADD; bsrc_o = BS_REG; end
      OP_SUB:  begin cls_o = CL_ALU2;   alu_op_o = ALU_SUB; bsrc_o = BS_REG; end
      OP_AND:  begin cls_o = CL_ALU2;   alu_op_o = ALU_AND; bsrc_o = BS_REG; end
      OP_OR:   begin cls_o = CL_ALU2;   alu_op_o = ALU_OR;  bsrc_o = BS_REG; end
      OP_XOR:  begin cls_o = CL_ALU2;   alu_op_o = ALU_XOR; bsrc_o = BS_REG; end
      OP_INV:  begin cls_o = CL_ALU1;   alu_op_o = ALU_INV; bsrc_o = BS_KEEP; end
      OP_INC:  begin cls_o = CL_INCDEC; alu_op_o = ALU_ADD; bsrc_o = BS_ONE; end
      OP_DEC:  begin cls_o = CL_INCDEC; alu_op_o = ALU_SUB; bsrc_o = BS_ONE; end
      OP_LOAD: cls_o = CL_LOAD;
      OP_JMP:  cls_o = CL_JMP;
      OP_JNZ:  cls_o = CL_JNZ;
      OP_HLT:  cls_o = CL_HLT;
      default: cls_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Hardwired fetch/decode/execute sequencer driving the ROM, 4x8 register file and ALU.
// Strobes are registered: each transition loads the strobe values of the state being entered.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ir_data,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic [DATA_W-1:0] alu_out,
  output logic [PC_W-1:0]   pc,
  output logic              ir_en,
  output logic [RA_W-1:0]   reg_addr,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              halted
);

  state_e              state_q;
  logic [15:0]         ir_q;
  logic [PC_W-1:0]     pc_q;
  logic                ir_en_q;
  logic [RA_W-1:0]     addr_q;
  logic                rd_q;
  logic                wr_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [2:0]          alu_op_q;
  logic                halted_q;

  logic [15:0]         dec_ir;
  logic [2:0]          cls;
  logic [2:0]          dec_alu_op;
  logic [1:0]          bsrc;
  logic [RA_W-1:0]     dst;
  logic [RA_W-1:0]     src_a;
  logic [RA_W-1:0]     src_b;
  logic [7:0]          imm;
  logic [PC_W-1:0]     pc_inc;
  logic                unused_ir_bits;

  // In DECODE the word is still on the ROM bus; afterwards it lives in ir_q.
  assign dec_ir = (state_q == ST_DECODE) ? ir_data : ir_q;
  assign dst    = dec_ir[DST_LO +: RA_W];
  assign src_a  = dec_ir[SRCA_LO +: RA_W];
  assign src_b  = dec_ir[SRCB_LO +: RA_W];
  assign imm    = dec_ir[IMM_LO +: 8];
  assign pc_inc = pc_q + PC_W'(1);
  assign unused_ir_bits = ^dec_ir[11:10];

  cpu_decode u_decode (
    .op_i     (dec_ir[OP_LO +: 4]),
    .cls_o    (cls),
    .alu_op_o (dec_alu_op),
    .bsrc_o   (bsrc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      ir_en_q  <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // Coming out of reset the enable is still low: raise it before moving on.
          if (ir_en_q) begin
            ir_en_q <= 1'b0;
            state_q <= ST_DECODE;
          end else begin
            ir_en_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          ir_q <= ir_data;
          case (cls)
            CL_ALU2, CL_ALU1, CL_INCDEC, CL_JNZ: begin
              rd_q    <= 1'b1;
              addr_q  <= (cls == CL_INCDEC || cls == CL_JNZ) ? dst : src_a;
              state_q <= ST_RD_A;
            end
            CL_LOAD: begin
              wr_q    <= 1'b1;
              addr_q  <= dst;
              state_q <= ST_WB;
            end
            CL_JMP: begin
              pc_q    <= PC_W'(imm);
              ir_en_q <= 1'b1;
              state_q <= ST_FETCH;
            end
            CL_HLT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            default: begin
              pc_q    <= pc_inc;
              ir_en_q <= 1'b1;
              state_q <= ST_FETCH;
            end
          endcase
        end
        ST_RD_A: begin
          state_q <= ST_RD_B;
          if (cls == CL_ALU2) begin
            rd_q   <= 1'b1;
            addr_q <= src_b;
          end else begin
            rd_q <= 1'b0;
          end
        end
        ST_RD_B: begin
          alu_a_q <= reg_rdata;
          rd_q    <= 1'b0;
          if (cls == CL_JNZ) begin
            pc_q    <= (reg_rdata != '0) ? PC_W'(imm) : pc_inc;
            ir_en_q <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (bsrc)
            BS_REG:  alu_b_q <= reg_rdata;
            BS_ONE:  alu_b_q <= DATA_W'(1);
            default: alu_b_q <= alu_b_q;
          endcase
          alu_op_q <= dec_alu_op;
          wr_q     <= 1'b1;
          addr_q   <= dst;
          state_q  <= ST_WB;
        end
        ST_WB: begin
          wr_q    <= 1'b0;
          pc_q    <= pc_inc;
          ir_en_q <= 1'b1;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Write data follows the ALU combinationally: operands settle only at the end of EXEC.
  assign reg_wdata = (state_q == ST_WB) ?
                     ((cls == CL_LOAD) ? DATA_W'(imm) : alu_out) : '0;

  assign pc       = pc_q;
  assign ir_en    = ir_en_q;
  assign reg_addr = addr_q;
  assign reg_rd   = rd_q;
  assign reg_wr   = wr_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: ROM, register file and ALU models around the controller,
// a vector table of single instructions plus hand sequences for wrap, halt and mid-reset.
module tb_cpu_control;

  logic        clk;
  logic        rst;
  logic [15:0] ir_data;
  logic [7:0]  reg_rdata;
  logic [7:0]  alu_out;
  logic [7:0]  pc;
  logic        ir_en;
  logic [1:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        halted;

  logic [15:0] rom [256];
  logic [7:0]  rf  [4];
  logic [7:0]  pre [4];

  int total = 0;
  int bad   = 0;
  int both_err = 0;

  cpu_control #(.PC_W(8), .DATA_W(8), .RA_W(2)) dut (
    .clk(clk), .rst(rst), .ir_data(ir_data), .reg_rdata(reg_rdata), .alu_out(alu_out),
    .pc(pc), .ir_en(ir_en), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM and register file; reset preloads the registers.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= pre[i];
    end else if (reg_wr) begin
      rf[reg_addr] <= reg_wdata;
    end
    if (ir_en)  ir_data   <= rom[pc];
    if (reg_rd) reg_rdata <= rf[reg_addr];
  end

  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = ~alu_a;
      default: alu_out = 8'h00;
    endcase
  end

  always @(negedge clk) if (reg_rd && reg_wr) both_err++;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  r0, r1, r2, r3;
    int          cyc;
    int          nwr;
    logic [1:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  pc;
    bit          chk_alu;
    logic [7:0]  a, b;
    logic [2:0]  op;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3);
    pre[0] = r0; pre[1] = r1; pre[2] = r2; pre[3] = r3;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rst_ctrl", {ir_en, reg_rd, reg_wr, halted, reg_addr, alu_op, pc}, 32'h0);
    chk("rst_data", {alu_a, alu_b, reg_wdata}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("fetch_c1", {ir_en, pc}, {1'b1, 8'h00});
  endtask

  // Runs from a fetch cycle up to the next fetch cycle.
  task automatic run_one(output int cyc, output int nwr,
                         output logic [1:0] wa, output logic [7:0] wd);
    cyc = 0; nwr = 0; wa = 2'd0; wd = 8'h00;
    do begin
      step();
      cyc++;
      if (reg_wr) begin
        nwr++;
        wa = reg_addr;
        wd = reg_wdata;
      end
    end while (!ir_en && cyc < 20);
    if (!ir_en) cyc = 99;
  endtask

  initial begin
    int cyc, nwr, viol;
    logic [1:0] wa;
    logic [7:0] wd;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h7000;

    //         ins       r0     r1     r2     r3    cyc nwr waddr wdata  pc    alu  a      b      op
    vt[0]  = '{16'h8105, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1, 2'd1, 8'h05, 8'h01, 1'b0, 8'h00, 8'h00, 3'd0};
    vt[1]  = '{16'h0201, 8'h03, 8'h05, 8'h00, 8'h00, 6, 1, 2'd2, 8'h08, 8'h01, 1'b1, 8'h03, 8'h05, 3'd0};
    vt[2]  = '{16'h1201, 8'h03, 8'h05, 8'h00, 8'h00, 6, 1, 2'd2, 8'hFE, 8'h01, 1'b1, 8'h03, 8'h05, 3'd1};
    vt[3]  = '{16'hB300, 8'h00, 8'h00, 8'h00, 8'h00, 6, 1, 2'd3, 8'hFF, 8'h01, 1'b1, 8'h00, 8'h01, 3'd1};
    vt[4]  = '{16'hA300, 8'h00, 8'h00, 8'h00, 8'hFF, 6, 1, 2'd3, 8'h00, 8'h01, 1'b1, 8'hFF, 8'h01, 3'd0};
    vt[5]  = '{16'hE140, 8'h00, 8'h00, 8'h00, 8'h00, 4, 0, 2'd0, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 3'd0};
    vt[6]  = '{16'hE140, 8'h00, 8'h02, 8'h00, 8'h00, 4, 0, 2'd0, 8'h00, 8'h40, 1'b0, 8'h00, 8'h00, 3'd0};
    vt[7]  = '{16'hF0FF, 8'h00, 8'h00, 8'h00, 8'h00, 2, 0, 2'd0, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 3'd0};
    vt[8]  = '{16'h7000, 8'h00, 8'h00, 8'h00, 8'h00, 2, 0, 2'd0, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 3'd0};
    vt[9]  = '{16'h9000, 8'h00, 8'h00, 8'h00, 8'h00, 2, 0, 2'd0, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 3'd0};
    vt[10] = '{16'h2223, 8'h00, 8'h00, 8'hF0, 8'h3C, 6, 1, 2'd2, 8'h30, 8'h01, 1'b1, 8'hF0, 8'h3C, 3'd2};
    vt[11] = '{16'h3223, 8'h00, 8'h00, 8'hF0, 8'h3C, 6, 1, 2'd2, 8'hFC, 8'h01, 1'b1, 8'hF0, 8'h3C, 3'd3};
    vt[12] = '{16'h4223, 8'h00, 8'h00, 8'hF0, 8'h3C, 6, 1, 2'd2, 8'hCC, 8'h01, 1'b1, 8'hF0, 8'h3C, 3'd4};
    vt[13] = '{16'h5120, 8'h00, 8'h00, 8'hF0, 8'h00, 6, 1, 2'd1, 8'h0F, 8'h01, 1'b1, 8'hF0, 8'h00, 3'd5};

    for (int i = 0; i < NV; i++) begin
      rom[0] = vt[i].ins;
      do_reset(vt[i].r0, vt[i].r1, vt[i].r2, vt[i].r3);
      run_one(cyc, nwr, wa, wd);
      chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d_nwr", i), nwr, vt[i].nwr);
      if (vt[i].nwr != 0) begin
        chk($sformatf("v%0d_waddr", i), wa, vt[i].waddr);
        chk($sformatf("v%0d_wdata", i), wd, vt[i].wdata);
      end
      chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
      if (vt[i].chk_alu) begin
        chk($sformatf("v%0d_alu_a", i), alu_a, vt[i].a);
        chk($sformatf("v%0d_alu_b", i), alu_b, vt[i].b);
        chk($sformatf("v%0d_alu_op", i), alu_op, vt[i].op);
      end
    end

    // JMP to 255, then a NOP there wraps pc to 0
    rom[0] = 16'hF0FF;
    rom[255] = 16'h7000;
    do_reset(8'h00, 8'h00, 8'h00, 8'h00);
    run_one(cyc, nwr, wa, wd);
    chk("jmp_pc", pc, 8'hFF);
    run_one(cyc, nwr, wa, wd);
    chk("wrap_cycles", cyc, 2);
    chk("wrap_pc", pc, 8'h00);

    // HLT is terminal until reset
    rom[0] = 16'hC000;
    do_reset(8'h00, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 10 && !halted; k++) step();
    chk("hlt_seen", halted, 1'b1);
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!halted || ir_en || reg_rd || reg_wr || pc != 8'h00) viol++;
    end
    chk("hlt_hold", viol, 0);
    rom[0] = 16'h7000;
    do_reset(8'h00, 8'h00, 8'h00, 8'h00);
    chk("hlt_cleared", halted, 1'b0);

    // Reset during an ADD's EXEC aborts the write
    rom[0] = 16'h0201;
    do_reset(8'h03, 8'h05, 8'h00, 8'h00);
    nwr = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (reg_wr) nwr++;
    end
    rst = 1'b1;
    step();
    if (reg_wr) nwr++;
    chk("abort_nwr", nwr, 0);
    chk("abort_state", {reg_wr, halted, pc}, 32'h0);
    chk("abort_r2", rf[2], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("abort_refetch", {ir_en, pc}, {1'b1, 8'h00});

    chk("rd_wr_overlap", both_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
